// File: rtl/i2c_slave_regs.sv
// I2C target with an 8-bit register pointer: pointer-then-data writes and
// auto-incrementing sequential reads through an external register-file port.
module i2c_slave_regs #(
   parameter logic [6:0] DEV_ADDR    = 7'h68,
   parameter int         SYNC_STAGES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   inout  wire        sda,
   input  logic [7:0] rd_data,
   output logic [7:0] rd_addr,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ADDR     = 3'd1;
   localparam logic [2:0] S_ADDR_ACK = 3'd2;
   localparam logic [2:0] S_WR_BYTE  = 3'd3;
   localparam logic [2:0] S_WR_ACK   = 3'd4;
   localparam logic [2:0] S_RD_BYTE  = 3'd5;
   localparam logic [2:0] S_RD_ACK   = 3'd6;

   logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
   logic [2:0] r_state, r_bitcnt;
   logic [7:0] r_shift, r_ptr, r_wr_addr, r_wr_data;
   logic       r_sda_oe, r_first, r_rw, r_mnack, r_busy, r_wr_en;

   // Sync flops idle high so reset release never fakes a bus edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
      end
   end

   logic w_scl_cur, w_scl_prev, w_sda_cur, w_sda_prev;
   logic w_scl_rise, w_scl_fall, w_start, w_stop;
   logic [7:0] w_byte;

   assign w_scl_cur  = r_scl_sync[SYNC_STAGES-2];
   assign w_scl_prev = r_scl_sync[SYNC_STAGES-1];
   assign w_sda_cur  = r_sda_sync[SYNC_STAGES-2];
   assign w_sda_prev = r_sda_sync[SYNC_STAGES-1];
   assign w_scl_rise = w_scl_cur & ~w_scl_prev;
   assign w_scl_fall = ~w_scl_cur & w_scl_prev;
   assign w_start    = w_scl_cur & w_scl_prev & w_sda_prev & ~w_sda_cur;
   assign w_stop     = w_scl_cur & w_scl_prev & ~w_sda_prev & w_sda_cur;
   assign w_byte     = {r_shift[6:0], w_sda_cur};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_bitcnt  <= 3'd0;
         r_shift   <= 8'h00;
         r_ptr     <= 8'h00;
         r_wr_addr <= 8'h00;
         r_wr_data <= 8'h00;
         r_sda_oe  <= 1'b0;
         r_first   <= 1'b0;
         r_rw      <= 1'b0;
         r_mnack   <= 1'b0;
         r_busy    <= 1'b0;
         r_wr_en   <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         if (w_start) begin
            r_state  <= S_ADDR;
            r_bitcnt <= 3'd0;
            r_sda_oe <= 1'b0;
         end else if (w_stop) begin
            r_state  <= S_IDLE;
            r_sda_oe <= 1'b0;
            r_busy   <= 1'b0;
         end else begin
            case (r_state)
               S_ADDR: if (w_scl_rise) begin
                  r_shift  <= w_byte;
                  r_bitcnt <= r_bitcnt + 3'd1;
                  if (r_bitcnt == 3'd7) begin
                     if (r_shift[6:0] == DEV_ADDR && DEV_ADDR != 7'h00) begin
                        r_state <= S_ADDR_ACK;
                        r_busy  <= 1'b1;
                        r_first <= 1'b1;
                        r_rw    <= w_sda_cur;
                     end else begin
                        r_state <= S_IDLE;
                     end
                  end
               end
               // bitcnt 0: waiting for the fall that starts the ACK; 1: driving it
               S_ADDR_ACK, S_WR_ACK: if (w_scl_fall) begin
                  if (r_bitcnt == 3'd0) begin
                     r_sda_oe <= 1'b1;
                     r_bitcnt <= 3'd1;
                  end else begin
                     r_bitcnt <= 3'd0;
                     if (r_state == S_ADDR_ACK && r_rw) begin
                        r_shift  <= rd_data;
                        r_sda_oe <= ~rd_data[7];
                        r_ptr    <= r_ptr + 8'd1;
                        r_state  <= S_RD_BYTE;
                     end else begin
                        r_sda_oe <= 1'b0;
                        r_state  <= S_WR_BYTE;
                     end
                  end
               end
               S_WR_BYTE: if (w_scl_rise) begin
                  r_shift  <= w_byte;
                  r_bitcnt <= r_bitcnt + 3'd1;
                  if (r_bitcnt == 3'd7) begin
                     r_state  <= S_WR_ACK;
                     r_bitcnt <= 3'd0;
                     if (r_first) begin
                        r_ptr   <= w_byte;
                        r_first <= 1'b0;
                     end else begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_ptr;
                        r_wr_data <= w_byte;
                        r_ptr     <= r_ptr + 8'd1;
                     end
                  end
               end
               S_RD_BYTE: if (w_scl_fall) begin
                  if (r_bitcnt == 3'd7) begin
                     r_sda_oe <= 1'b0;
                     r_bitcnt <= 3'd0;
                     r_state  <= S_RD_ACK;
                  end else begin
                     r_shift  <= {r_shift[6:0], 1'b0};
                     r_sda_oe <= ~r_shift[6];
                     r_bitcnt <= r_bitcnt + 3'd1;
                  end
               end
               S_RD_ACK: begin
                  if (w_scl_rise && r_bitcnt == 3'd0) begin
                     r_mnack  <= w_sda_cur;
                     r_bitcnt <= 3'd1;
                  end else if (w_scl_fall && r_bitcnt == 3'd1) begin
                     r_bitcnt <= 3'd0;
                     if (!r_mnack) begin
                        r_shift  <= rd_data;
                        r_sda_oe <= ~rd_data[7];
                        r_ptr    <= r_ptr + 8'd1;
                        r_state  <= S_RD_BYTE;
                     end else begin
                        r_sda_oe <= 1'b0;
                        r_state  <= S_IDLE;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign sda     = r_sda_oe ? 1'b0 : 1'bz;
   assign rd_addr = r_ptr;
   assign wr_en   = r_wr_en;
   assign wr_addr = r_wr_addr;
   assign wr_data = r_wr_data;
   assign busy    = r_busy;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bit-banged I2C master against i2c_slave_regs with a byte-level register model.
module tb_i2c_slave_regs;

   localparam int Q = 50;

   logic       clk = 1'b0, rst = 1'b1, scl = 1'b1, m_low = 1'b0;
   wire        sda;
   logic [7:0] rd_data, rd_addr, wr_addr, wr_data;
   logic       wr_en, busy;

   logic [7:0]  tb_mem  [256];
   logic [7:0]  exp_mem [256];
   logic [7:0]  exp_ptr;
   logic [7:0]  data_q [$];
   logic [15:0] wr_log [$];
   logic [15:0] exp_wr [$];
   int n_chk = 0, n_fail = 0;

   pullup (sda);
   assign sda     = m_low ? 1'b0 : 1'bz;
   assign rd_data = tb_mem[rd_addr];

   i2c_slave_regs #(.DEV_ADDR(7'h68), .SYNC_STAGES(3)) dut (
      .clk(clk), .rst(rst), .scl(scl), .sda(sda), .rd_data(rd_data),
      .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_en) begin
         wr_log.push_back({wr_addr, wr_data});
         tb_mem[wr_addr] = wr_data;
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic bit_xfer(input logic b, output logic r);
      #Q; m_low = ~b;
      #Q; scl = 1'b1;
      #Q; r = sda;
      #Q; scl = 1'b0;
   endtask

   task automatic start_c();
      m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0;
   endtask

   task automatic stop_c();
      #Q; m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #(2*Q);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
      bit_xfer(1'b1, r);
      ack = ~r;
   endtask

   task automatic recv_byte(input logic mack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, r);
         d[i] = r;
      end
      bit_xfer(~mack, r);
   endtask

   // pointer byte then data_q bytes; model: pointer set, each byte stored then pointer+1
   task automatic do_write(input logic [7:0] ptr, input string tag);
      logic ack;
      wr_log.delete(); exp_wr.delete();
      start_c();
      send_byte(8'hD0, ack); chk({tag, " addr ack"}, ack, 1);
      send_byte(ptr, ack);   chk({tag, " ptr ack"}, ack, 1);
      exp_ptr = ptr;
      foreach (data_q[i]) begin
         send_byte(data_q[i], ack); chk({tag, " data ack"}, ack, 1);
         exp_wr.push_back({exp_ptr, data_q[i]});
         exp_mem[exp_ptr] = data_q[i];
         exp_ptr++;
      end
      chk({tag, " busy"}, busy, 1);
      stop_c();
      chk({tag, " wr count"}, wr_log.size(), exp_wr.size());
      for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
         chk({tag, " wr addr/data"}, wr_log[i], exp_wr[i]);
      chk({tag, " rd_addr"}, rd_addr, exp_ptr);
      chk({tag, " busy after stop"}, busy, 0);
   endtask

   task automatic do_read(input bit set_ptr, input logic [7:0] ptr, input int n, input string tag);
      logic ack;
      logic [7:0] d;
      wr_log.delete();
      start_c();
      if (set_ptr) begin
         send_byte(8'hD0, ack); chk({tag, " w addr ack"}, ack, 1);
         send_byte(ptr, ack);   chk({tag, " ptr ack"}, ack, 1);
         exp_ptr = ptr;
         start_c();
      end
      send_byte(8'hD1, ack); chk({tag, " r addr ack"}, ack, 1);
      for (int i = 0; i < n; i++) begin
         recv_byte(i < n - 1, d);
         chk({tag, " rd byte"}, d, exp_mem[exp_ptr]);
         exp_ptr++;
      end
      #Q;
      chk({tag, " sda released"}, sda, 1);
      chk({tag, " busy held"}, busy, 1);
      stop_c();
      chk({tag, " rd_addr"}, rd_addr, exp_ptr);
      chk({tag, " no wr"}, wr_log.size(), 0);
      chk({tag, " busy after stop"}, busy, 0);
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic ack, r;
      logic [7:0] b;
      for (int a = 0; a < 256; a++) begin
         tb_mem[a]  = 8'(a + 16);
         exp_mem[a] = 8'(a + 16);
      end
      exp_ptr = 8'h00;
      #33 rst = 1'b0;
      #20;
      chk("reset sda", sda, 1);
      chk("reset wr_en", wr_en, 0);
      chk("reset wr_addr", wr_addr, 0);
      chk("reset wr_data", wr_data, 0);
      chk("reset rd_addr", rd_addr, 0);
      chk("reset busy", busy, 0);

      data_q = '{8'h00};
      do_write(8'h6B, "wr6B");

      do_read(1'b1, 8'h3B, 6, "burst3B");

      // foreign and general-call addresses are ignored
      wr_log.delete();
      start_c(); send_byte(8'hA0, ack); chk("A0 no ack", ack, 0);
      chk("A0 busy", busy, 0); stop_c();
      start_c(); send_byte(8'h00, ack); chk("gc no ack", ack, 0);
      chk("gc busy", busy, 0); stop_c();
      chk("bad addr no wr", wr_log.size(), 0);
      data_q = '{};
      do_write(8'h20, "after bad");

      data_q = '{8'h11, 8'h22, 8'h33};
      do_write(8'hFE, "wrap");

      // STOP after 4 data bits must not produce a write
      wr_log.delete();
      start_c();
      send_byte(8'hD0, ack); chk("abort addr ack", ack, 1);
      send_byte(8'h30, ack); chk("abort ptr ack", ack, 1);
      exp_ptr = 8'h30;
      bit_xfer(1'b1, r); bit_xfer(1'b0, r); bit_xfer(1'b1, r); bit_xfer(1'b0, r);
      stop_c();
      chk("abort no wr", wr_log.size(), 0);
      chk("abort rd_addr", rd_addr, exp_ptr);
      data_q = '{8'h07};
      do_write(8'h19, "wr19");

      // reset while the target drives a 0 data bit (mem[20]=30, MSB 0)
      data_q = '{};
      do_write(8'h20, "rst setup");
      start_c();
      send_byte(8'hD1, ack); chk("rst r ack", ack, 1);
      #Q;
      chk("rst bit7 driven", sda, 0);
      rst = 1'b1;
      #1;
      chk("rst sda", sda, 1);
      chk("rst wr_en", wr_en, 0);
      chk("rst wr_addr", wr_addr, 0);
      chk("rst wr_data", wr_data, 0);
      chk("rst rd_addr", rd_addr, 0);
      chk("rst busy", busy, 0);
      #30 rst = 1'b0;
      exp_ptr = 8'h00;
      m_low = 1'b0; #Q; scl = 1'b1; #(2*Q);
      data_q = '{8'h5A};
      do_write(8'h05, "post rst wr");
      do_read(1'b1, 8'h05, 1, "post rst rd");

      for (int it = 0; it < 16; it++) begin
         int op, n;
         op = $urandom_range(0, 2);
         if (op == 0) begin
            n = $urandom_range(0, 3);
            data_q = '{};
            for (int k = 0; k < n; k++) begin
               b = 8'($urandom);
               data_q.push_back(b);
            end
            do_write(8'($urandom), "rnd wr");
         end else begin
            n = $urandom_range(1, 4);
            do_read(op == 1, 8'($urandom), n, "rnd rd");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
